tdc_rx_deser: RTL and testbench
===============================

Name: tdc_rx_deser

Overview:
Receive-side deserializer for the serial DATA_OUT stream produced by the TDC core. It frames the single-wire stream into DATA_WIDTH-bit words, checks parity and stop bits, and buffers good words in a small show-ahead FIFO. The firmware core pops the FIFO and reads its status counters over the register bus. Bit timing comes from a one-cycle BIT_EN strobe generated in the same clock domain, so the block has no second clock.

Parameters:
DATA_WIDTH, 16, payload bits per frame
FIFO_DEPTH, 8, word FIFO depth; must be a power of 2
CNT_WIDTH, 16, width of the status counters

Ports:
BUS_CLK  in  1  single clock for the whole block
BUS_RST  in  1  reset; asynchronous, active-high
ENABLE  in  1  receiver enable
BIT_EN  in  1  one-cycle strobe marking each serial bit period
RX_DATA  in  1  serial stream from the TDC core
CLEAR_CNT  in  1  synchronous clear of all counters
DATA  out  DATA_WIDTH  FIFO head word
DATA_VALID  out  1  FIFO not empty
DATA_READ  in  1  pop strobe; honoured only when DATA_VALID=1
FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
FRAME_CNT  out  CNT_WIDTH  good frames received, including frames lost to overflow
ERR_CNT  out  CNT_WIDTH  parity plus framing errors
LOST_CNT  out  CNT_WIDTH  good frames dropped because the FIFO was full

Behaviour:
- Reset: all outputs are 0, the FSM is IDLE, the FIFO is empty, and both sync stages are 0.
- Line format:
  - The line idles at 0.
  - Start bit is 1.
  - DATA_WIDTH payload bits follow, MSB first.
  - One even-parity bit follows; XOR of payload and parity must be 0.
  - Stop bit is 0.
- Input alignment: RX_DATA passes through 2 flops, and BIT_EN is delayed by the same 2 flops. All FSM actions occur on the delayed strobe (ben_d) using the delayed data (rx_d).
- FSM, advancing only on ben_d:
  - IDLE: if rx_d=1 and ENABLE=1, clear the shift register and bit counter, then go to DATA.
  - DATA: shift rx_d into the LSB. After DATA_WIDTH bits, go to PARITY.
  - PARITY: latch parity_ok, then go to STOP.
  - STOP, if rx_d=0 and parity_ok: the frame is good. Push the word on the next cycle and increment FRAME_CNT.
  - STOP, otherwise: drop the word and increment ERR_CNT.
  - STOP always returns to IDLE.
  - A stop bit of 1 is a framing error. The FSM resynchronises because the next ben_d with rx_d=1 is taken as a start bit.
- ENABLE=0 in any state: the FSM goes to IDLE on the next cycle and discards the partial frame. FIFO contents and counters are kept.
- Latency: a stop-bit strobe at the BIT_EN input in cycle N pushes the word in cycle N+3. With the FIFO previously empty, DATA_VALID=1 and DATA shows the word in cycle N+3.
- FIFO (show-ahead):
  - DATA always shows the head word.
  - DATA_READ with DATA_VALID=1 pops in that cycle.
  - DATA_READ with DATA_VALID=0 is ignored.
  - Push while full with no pop: the word is dropped and LOST_CNT increments.
  - Push and pop in the same cycle while full: the pop wins first, the push succeeds, and nothing is lost.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - All counters saturate at all-ones.
  - CLEAR_CNT zeroes all counters and takes priority over a same-cycle increment.
  - CLEAR_CNT does not affect the FIFO.
- Reset asserted mid-frame: immediate return to the reset state. The FIFO is emptied.

Decomposition:
- Package tdc_rx_pkg holds:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Constants START_BIT=1, STOP_BIT=0, SYNC_STAGES=2.
  - A saturating-increment function.
- Sub-module tdc_rx_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH. It outputs full, empty and count, and supports simultaneous push and pop. Reset is asynchronous and active-high.
- The top level holds the sync stages, FSM, shift register and counters.

Test Plan:
Common setup for all scenarios: DATA_WIDTH=16, FIFO_DEPTH=8, BIT_EN every 10 cycles.
1. Frame 0xA5C3 with parity 0 -> DATA=0xA5C3 and DATA_VALID=1 exactly 3 cycles after the stop-bit strobe; FRAME_CNT=1, ERR_CNT=0.
2. Frame 0x0001 with wrong parity 0 -> nothing pushed; ERR_CNT=1. Then frame 0x0001 with parity 1 -> DATA=0x0001; FRAME_CNT=1.
3. Ten good frames 0x0000..0x0009 with no reads -> FIFO_COUNT=8, LOST_CNT=2, FRAME_CNT=10. Popping returns 0x0000..0x0007 in order, and DATA_VALID=0 afterwards.
4. ENABLE dropped after 5 payload bits, then re-enabled -> nothing pushed. Next frame 0x1234 with parity 1 is received correctly.
5. Frame 0xBEEF with stop bit 1 -> ERR_CNT=1, nothing pushed. Immediately following frame 0x00FF with parity 0 is received.
6. CLEAR_CNT asserted in the same cycle as an error increment -> ERR_CNT=0. BUS_RST pulsed mid-frame with 3 words queued -> FIFO_COUNT=0, DATA=0, FSM in IDLE.

Source files
------------

// File: rtl/tdc_rx_pkg.sv
// -----------------------------------------------------------------------------
// tdc_rx_pkg
// Shared definitions for the TDC serial receive path: receiver FSM states,
// line-level constants and a saturating counter helper.
// -----------------------------------------------------------------------------
package tdc_rx_pkg;

    // Receiver frame states: wait for start, payload bits, parity bit, stop bit.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT   = 1'b1;
    localparam logic STOP_BIT    = 1'b0;
    localparam int   SYNC_STAGES = 2;

    // Increment value, holding at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/tdc_rx_fifo.sv
// -----------------------------------------------------------------------------
// tdc_rx_fifo
// Show-ahead FIFO: dout always presents the head word (0 while empty), a pop
// takes effect in the cycle it is asserted. Push and pop may coincide; when
// full, a coincident pop frees the slot so the push is accepted.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   push, din    write request and word
//   pop          read request, ignored while empty
//   dout         head word
//   full, empty  occupancy flags
//   count        current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module tdc_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A same-cycle pop makes room, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale words are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/tdc_rx_deser.sv
// -----------------------------------------------------------------------------
// tdc_rx_deser
// Deserializer for the TDC core's single-wire DATA_OUT stream. Frame format:
// start bit (1), DATA_WIDTH payload bits MSB first, even parity bit, stop bit
// (0); the line idles at 0. Good words are queued in a show-ahead FIFO, and
// good/error/lost frames are counted with saturating counters.
//
// Ports:
//   BUS_CLK, BUS_RST  clock, asynchronous active-high reset
//   ENABLE            receiver enable; low forces the FSM to IDLE
//   BIT_EN            one-cycle strobe per serial bit period
//   RX_DATA           serial line
//   CLEAR_CNT         synchronous clear of all counters (wins over increments)
//   DATA, DATA_VALID  FIFO head word and not-empty flag
//   DATA_READ         pop strobe, honoured when DATA_VALID=1
//   FIFO_COUNT        FIFO occupancy
//   FRAME_CNT         good frames (including ones dropped on overflow)
//   ERR_CNT           parity and framing errors
//   LOST_CNT          good frames dropped because the FIFO was full
// -----------------------------------------------------------------------------
module tdc_rx_deser
    import tdc_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          BUS_CLK,
    input  logic                          BUS_RST,
    input  logic                          ENABLE,
    input  logic                          BIT_EN,
    input  logic                          RX_DATA,
    input  logic                          CLEAR_CNT,
    output logic [DATA_WIDTH-1:0]         DATA,
    output logic                          DATA_VALID,
    input  logic                          DATA_READ,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic [CNT_WIDTH-1:0]          FRAME_CNT,
    output logic [CNT_WIDTH-1:0]          ERR_CNT,
    output logic [CNT_WIDTH-1:0]          LOST_CNT
);

    localparam int BCW = $clog2(DATA_WIDTH);

    // Data and strobe go through identical delay chains so they stay aligned.
    logic [SYNC_STAGES-1:0] rx_sync_reg;
    logic [SYNC_STAGES-1:0] ben_sync_reg;
    logic                   rx_d;
    logic                   ben_d;

    rx_state_t              state_reg,     state_next;
    logic [DATA_WIDTH-1:0]  shift_reg,     shift_next;
    logic [BCW-1:0]         bit_cnt_reg,   bit_cnt_next;
    logic                   parity_ok_reg, parity_ok_next;
    logic                   frame_good;
    logic                   frame_err;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   lost_inc;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            rx_sync_reg  <= '0;
            ben_sync_reg <= '0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[SYNC_STAGES-2:0], RX_DATA};
            ben_sync_reg <= {ben_sync_reg[SYNC_STAGES-2:0], BIT_EN};
        end
    end

    assign rx_d  = rx_sync_reg[SYNC_STAGES-1];
    assign ben_d = ben_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            parity_ok_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            parity_ok_reg <= parity_ok_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        parity_ok_next = parity_ok_reg;
        frame_good     = 1'b0;
        frame_err      = 1'b0;

        if (!ENABLE) begin
            state_next = ST_IDLE;
        end else if (ben_d) begin
            case (state_reg)
                ST_IDLE: begin
                    if (rx_d == START_BIT) begin
                        shift_next   = '0;
                        bit_cnt_next = '0;
                        state_next   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_next = {shift_reg[DATA_WIDTH-2:0], rx_d};
                    if (bit_cnt_reg == BCW'(DATA_WIDTH - 1)) begin
                        state_next = ST_PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BCW'(1);
                    end
                end
                ST_PARITY: begin
                    parity_ok_next = ((^shift_reg) ^ rx_d) == 1'b0;
                    state_next     = ST_STOP;
                end
                ST_STOP: begin
                    // A stop bit of 1 is dropped here; the FSM relocks on the
                    // next strobe that carries a 1.
                    if (rx_d == STOP_BIT && parity_ok_reg) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign fifo_pop = DATA_READ && !fifo_empty;
    assign lost_inc = frame_good && fifo_full && !fifo_pop;

    tdc_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (BUS_CLK),
        .rst   (BUS_RST),
        .push  (frame_good),
        .din   (shift_reg),
        .pop   (DATA_READ),
        .dout  (DATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (FIFO_COUNT)
    );

    assign DATA_VALID = !fifo_empty;

    // Status counters: index 0 frames, 1 errors, 2 lost.
    logic [2:0]                 cnt_inc;
    logic [2:0][CNT_WIDTH-1:0]  cnt_all;

    assign cnt_inc = {lost_inc, frame_err, frame_good};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
                if (BUS_RST) begin
                    cnt_reg <= '0;
                end else if (CLEAR_CNT) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= CNT_WIDTH'(sat_inc(32'(cnt_reg), CNT_WIDTH));
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign FRAME_CNT = cnt_all[0];
    assign ERR_CNT   = cnt_all[1];
    assign LOST_CNT  = cnt_all[2];

endmodule

// File: tb/tb_tdc_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_tdc_rx_deser
// Directed scenarios followed by randomized frames. A transaction-level model
// (queue of words plus integer counters, updated when a frame's outcome takes
// effect three cycles after its stop-bit strobe) is compared with the DUT on
// every cycle; directed steps add hand-computed literal expectations.
// Counters are built 4 bits wide so saturation is reached in a short run.
// -----------------------------------------------------------------------------
module tb_tdc_rx_deser;

    localparam int DW   = 16;
    localparam int FD   = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          BUS_CLK;
    logic          BUS_RST;
    logic          ENABLE;
    logic          BIT_EN;
    logic          RX_DATA;
    logic          CLEAR_CNT;
    logic [DW-1:0] DATA;
    logic          DATA_VALID;
    logic          DATA_READ;
    logic [3:0]    FIFO_COUNT;
    logic [CW-1:0] FRAME_CNT;
    logic [CW-1:0] ERR_CNT;
    logic [CW-1:0] LOST_CNT;

    tdc_rx_deser #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .BUS_CLK    (BUS_CLK),
        .BUS_RST    (BUS_RST),
        .ENABLE     (ENABLE),
        .BIT_EN     (BIT_EN),
        .RX_DATA    (RX_DATA),
        .CLEAR_CNT  (CLEAR_CNT),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READ  (DATA_READ),
        .FIFO_COUNT (FIFO_COUNT),
        .FRAME_CNT  (FRAME_CNT),
        .ERR_CNT    (ERR_CNT),
        .LOST_CNT   (LOST_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned   due;
        bit            good;
        logic [DW-1:0] word;
    } ev_t;

    ev_t           pend[$];
    logic [DW-1:0] mq[$];
    int            m_frame;
    int            m_err;
    int            m_lost;
    int unsigned   cyc;
    bit            started;
    bit            rnd_on;
    int unsigned   rd_div;
    bit            m_have;
    bit            m_pop;
    ev_t           m_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Reference model: one update per rising edge from the inputs seen there.
    initial begin
        cyc = 0; m_frame = 0; m_err = 0; m_lost = 0;
        forever begin
            @(posedge BUS_CLK);
            cyc++;
            if (BUS_RST) begin
                mq.delete();
                pend.delete();
                m_frame = 0; m_err = 0; m_lost = 0;
            end else begin
                m_have = (pend.size() > 0) && (pend[0].due == cyc);
                m_pop  = DATA_READ && (mq.size() > 0);
                if (m_have) m_ev = pend.pop_front();
                if (m_pop) mq.delete(0);
                if (CLEAR_CNT) begin
                    m_frame = 0; m_err = 0; m_lost = 0;
                end
                if (m_have && m_ev.good) begin
                    if (mq.size() < FD) mq.push_back(m_ev.word);
                    else if (!CLEAR_CNT) m_lost = sat(m_lost);
                    if (!CLEAR_CNT) m_frame = sat(m_frame);
                end
                if (m_have && !m_ev.good && !CLEAR_CNT) m_err = sat(m_err);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge BUS_CLK);
            if (started && !BUS_RST) begin
                chk("valid", 32'(DATA_VALID), 32'(mq.size() != 0));
                if (mq.size() != 0) chk("data", 32'(DATA), 32'(mq[0]));
                chk("fifo_count", 32'(FIFO_COUNT), 32'(mq.size()));
                chk("frame_cnt", 32'(FRAME_CNT), 32'(m_frame));
                chk("err_cnt", 32'(ERR_CNT), 32'(m_err));
                chk("lost_cnt", 32'(LOST_CNT), 32'(m_lost));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
        if (rnd_on) begin
            DATA_READ = ($urandom_range(rd_div - 1, 0) == 0);
            CLEAR_CNT = ($urandom_range(1999, 0) == 0);
        end
    endtask

    // One serial bit: line held for 10 cycles, strobe in the last one.
    task automatic bit_period(input logic b, input bit mark,
                              input logic [DW-1:0] w, input bit good);
        ev_t e;
        RX_DATA = b;
        BIT_EN  = 1'b0;
        repeat (9) tick();
        BIT_EN = 1'b1;
        if (mark) begin
            e.due  = cyc + 3;
            e.good = good;
            e.word = w;
            pend.push_back(e);
        end
        tick();
        BIT_EN = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input logic par, input logic stp);
        bit good;
        good = (((^w) ^ par) == 1'b0) && (stp == 1'b0);
        bit_period(1'b1, 1'b0, w, good);
        for (int i = DW - 1; i >= 0; i--) bit_period(w[i], 1'b0, w, good);
        bit_period(par, 1'b0, w, good);
        bit_period(stp, 1'b1, w, good);
        $display("frame %04h parity %0b stop %0b -> %s", w, par, stp, good ? "good" : "bad");
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 64) begin
            DATA_READ = 1'b1;
            tick();
            guard++;
        end
        DATA_READ = 1'b0;
        tick();
    endtask

    task automatic clear_cnt();
        CLEAR_CNT = 1'b1;
        tick();
        CLEAR_CNT = 1'b0;
        tick();
    endtask

    initial begin
        logic [DW-1:0] w;
        int            gap;

        BUS_RST = 1'b1; ENABLE = 1'b0; BIT_EN = 1'b0; RX_DATA = 1'b0;
        CLEAR_CNT = 1'b0; DATA_READ = 1'b0; rnd_on = 1'b0; rd_div = 4; started = 1'b0;
        repeat (3) tick();
        BUS_RST = 1'b0;
        ENABLE  = 1'b1;
        started = 1'b1;

        // Reset state
        chk("rst_data", 32'(DATA), 32'h0);
        chk("rst_valid", 32'(DATA_VALID), 32'h0);
        chk("rst_count", 32'(FIFO_COUNT), 32'h0);
        chk("rst_frame", 32'(FRAME_CNT), 32'h0);
        chk("rst_err", 32'(ERR_CNT), 32'h0);
        chk("rst_lost", 32'(LOST_CNT), 32'h0);
        repeat (5) tick();

        // 1: latency of a good frame
        send_frame(16'hA5C3, 1'b0, 1'b0);
        tick();
        chk("s1_valid_n2", 32'(DATA_VALID), 32'h0);
        tick();
        chk("s1_valid_n3", 32'(DATA_VALID), 32'h1);
        chk("s1_data", 32'(DATA), 32'hA5C3);
        chk("s1_frame", 32'(FRAME_CNT), 32'h1);
        chk("s1_err", 32'(ERR_CNT), 32'h0);
        drain(); clear_cnt();

        // 2: parity error, then the same word with correct parity
        send_frame(16'h0001, 1'b0, 1'b0);
        repeat (3) tick();
        chk("s2_err", 32'(ERR_CNT), 32'h1);
        chk("s2_count", 32'(FIFO_COUNT), 32'h0);
        send_frame(16'h0001, 1'b1, 1'b0);
        repeat (3) tick();
        chk("s2_data", 32'(DATA), 32'h0001);
        chk("s2_frame", 32'(FRAME_CNT), 32'h1);
        drain(); clear_cnt();

        // 3: overflow, ordered pops, then full with pop in the push cycle
        for (int i = 0; i < 10; i++) begin
            w = 16'(i);
            send_frame(w, ^w, 1'b0);
        end
        repeat (3) tick();
        chk("s3_count", 32'(FIFO_COUNT), 32'h8);
        chk("s3_lost", 32'(LOST_CNT), 32'h2);
        chk("s3_frame", 32'(FRAME_CNT), 32'hA);
        for (int i = 0; i < 8; i++) begin
            chk("s3_pop_data", 32'(DATA), 32'(i));
            DATA_READ = 1'b1;
            tick();
            DATA_READ = 1'b0;
        end
        chk("s3_empty", 32'(DATA_VALID), 32'h0);
        for (int i = 0; i < 8; i++) begin
            w = 16'(32 + i);
            send_frame(w, ^w, 1'b0);
        end
        send_frame(16'h0028, 1'b0, 1'b0);
        tick();
        DATA_READ = 1'b1;
        tick();
        DATA_READ = 1'b0;
        tick();
        chk("s3_fullpop_count", 32'(FIFO_COUNT), 32'h8);
        chk("s3_fullpop_lost", 32'(LOST_CNT), 32'h2);
        chk("s3_frame_sat", 32'(FRAME_CNT), 32'hF);
        chk("s3_fullpop_head", 32'(DATA), 32'h0021);
        drain(); clear_cnt();

        // 4: enable dropped mid-frame
        bit_period(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) bit_period(1'b1, 1'b0, '0, 1'b0);
        ENABLE = 1'b0;
        RX_DATA = 1'b0;
        repeat (30) tick();
        ENABLE = 1'b1;
        repeat (30) tick();
        chk("s4_count", 32'(FIFO_COUNT), 32'h0);
        chk("s4_err", 32'(ERR_CNT), 32'h0);
        send_frame(16'h1234, 1'b1, 1'b0);
        repeat (3) tick();
        chk("s4_data", 32'(DATA), 32'h1234);
        chk("s4_frame", 32'(FRAME_CNT), 32'h1);
        drain(); clear_cnt();

        // 5: framing error immediately followed by a good frame
        send_frame(16'hBEEF, 1'b1, 1'b1);
        send_frame(16'h00FF, 1'b0, 1'b0);
        repeat (3) tick();
        chk("s5_err", 32'(ERR_CNT), 32'h1);
        chk("s5_frame", 32'(FRAME_CNT), 32'h1);
        chk("s5_count", 32'(FIFO_COUNT), 32'h1);
        chk("s5_data", 32'(DATA), 32'h00FF);
        drain(); clear_cnt();

        // 6: clear wins over an error increment; reset mid-frame
        send_frame(16'h0003, 1'b1, 1'b0);
        repeat (3) tick();
        chk("s6_err1", 32'(ERR_CNT), 32'h1);
        send_frame(16'h0007, 1'b0, 1'b0);
        tick();
        CLEAR_CNT = 1'b1;
        tick();
        CLEAR_CNT = 1'b0;
        chk("s6_clr_err", 32'(ERR_CNT), 32'h0);
        send_frame(16'h0011, 1'b0, 1'b0);
        send_frame(16'h0022, 1'b0, 1'b0);
        send_frame(16'h0033, 1'b0, 1'b0);
        repeat (3) tick();
        chk("s6_queued", 32'(FIFO_COUNT), 32'h3);
        bit_period(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) bit_period(1'b1, 1'b0, '0, 1'b0);
        BUS_RST = 1'b1;
        #2;
        chk("s6_rst_count", 32'(FIFO_COUNT), 32'h0);
        chk("s6_rst_data", 32'(DATA), 32'h0);
        chk("s6_rst_valid", 32'(DATA_VALID), 32'h0);
        tick();
        BUS_RST = 1'b0;
        RX_DATA = 1'b0;
        repeat (20) tick();
        send_frame(16'h5A5A, 1'b0, 1'b0);
        repeat (3) tick();
        chk("s6_after_rst_data", 32'(DATA), 32'h5A5A);
        chk("s6_after_rst_frame", 32'(FRAME_CNT), 32'h1);
        drain(); clear_cnt();

        // Random frames: first with rare reads (overflow, saturation), then busy reads
        rnd_on = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rd_div = (f < 20) ? 400 : 4;
            w = 16'($urandom);
            send_frame(w, (^w) ^ ($urandom_range(6, 0) == 0), ($urandom_range(9, 0) == 0));
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) bit_period(1'b0, 1'b0, '0, 1'b0);
        end
        rnd_on = 1'b0;
        DATA_READ = 1'b0;
        CLEAR_CNT = 1'b0;
        repeat (5) tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
